ha1588_axi_lite_bridge: RTL
===========================

// Module: ha1588_axi_lite_bridge
// PURPOSE
//  Full AXI4-Lite slave to ha1588 local-bus bridge; replaces the tie-off style wrapper.
//  - AW and W channels are independent and may arrive in either order.
//  - Write strobes are forwarded to the local bus; B and R responses are held until accepted.
//  - A local maskable interrupt controller (pending/enable) drives INTR_OUT.
//  - Sits between the AXI interconnect and the ha1588 register file (up_* bus).
// PARAMETERS
//  C_S_AXI_REG_ADDR_WIDTH  32    AXI address width.
//  C_S_AXI_REG_DATA_WIDTH  32    AXI data width; fixed at 32.
//  C_UP_ADDR_WIDTH         8     Local-bus byte address width.
//  C_RD_LATENCY            1     Cycles from the up_rd cycle to valid up_data_rd; legal range 1..4.
//  C_INTR_WIDTH            4     Number of interrupt sources; legal range 1..32.
//  C_INTR_BASE             8'hF0 Local interrupt window: PEND at BASE+0, EN at BASE+4.
// PORTS
//  S_AXI_REG_ACLK     in   1      Clock.
//  S_AXI_REG_ARESETN  in   1      Reset, asynchronous, active-low.
//  S_AXI_REG_AW{ADDR,PROT,VALID}/AWREADY  in/in/in/out  ADDR_W/3/1/1   Write address channel.
//  S_AXI_REG_W{DATA,STRB,VALID}/WREADY    in/in/in/out  32/4/1/1       Write data channel.
//  S_AXI_REG_B{RESP,VALID}/BREADY         out/out/in    2/1/1          Write response channel.
//  S_AXI_REG_AR{ADDR,PROT,VALID}/ARREADY  in/in/in/out  ADDR_W/3/1/1   Read address channel.
//  S_AXI_REG_R{DATA,RESP,VALID}/RREADY    out/out/out/in 32/2/1/1      Read data channel.
//  INTR_OUT           out  1      Level interrupt, registered.
//  irq_src            in   C_INTR_WIDTH  Async interrupt sources; rising edge is the event.
//  up_wr / up_rd      out  1      Single-cycle local write / read strobes.
//  up_addr            out  C_UP_ADDR_WIDTH  Local byte address = AxADDR[C_UP_ADDR_WIDTH-1:0].
//  up_be              out  4      Byte enables = WSTRB.
//  up_data_wr         out  32     Write data.
//  up_data_rd         in   32     Read data.
// BEHAVIOUR
//  - Reset values: all READY outputs 0 during reset, then 1 when their holding register is empty.
//    BVALID=0, RVALID=0, BRESP=RRESP=2'b00, RDATA=0, INTR_OUT=0, up_*=0, PEND=0, EN=0.
//  - Holding registers: one each for AW, W and AR, each with a full flag.
//    AxREADY/WREADY = !full. A handshake sets full; the FSM consumes the entry and clears full.
//  - FSM states: IDLE, WR, BRSP, RD, RWAIT, RRSP.
//    IDLE: a write is ready when AW and W are both full; a read is ready when AR is full.
//    If both are ready, arbitration is round-robin; the first grant after reset goes to write.
//  - WR (1 cycle): up_wr=1 with up_addr/up_be/up_data_wr from the holding registers.
//    up_wr is suppressed when WSTRB==0 or the address is in the interrupt window.
//    Clears AW and W full. Next state BRSP.
//  - BRSP: BVALID=1, BRESP=OKAY; held until BREADY, then IDLE.
//  - RD (1 cycle): up_rd=1 (suppressed in the interrupt window); clears AR full. Next state RWAIT.
//  - RWAIT: counts C_RD_LATENCY cycles. On the last cycle it registers up_data_rd
//    (or PEND/EN, zero-extended) into RDATA. Next state RRSP.
//  - RRSP: RVALID=1; RDATA and RRESP stay stable until RREADY, then IDLE.
//  - Latency (C_RD_LATENCY=1): AR handshake at edge 0, up_rd in cycle 1, RVALID from cycle 3.
//    Write: AW+W complete at edge 0, up_wr in cycle 1, BVALID from cycle 2.
//  - New AW/W/AR may be accepted while a response is pending (one-deep skid per channel).
//  - Address decode: upper address bits and AxPROT are ignored; no SLVERR/DECERR is generated.
//  - Interrupts:
//    - irq_src passes a 2-flop synchronizer. A rising edge of the synchronized signal sets PEND[i].
//    - A write to PEND clears bits written as 1 (W1C, byte-strobe qualified).
//      If a set and a clear hit the same bit in the same cycle, the set wins.
//    - A write to EN loads the bits (byte-strobe qualified).
//    - INTR_OUT <= |(PEND & EN), registered one cycle.
//  - Reset mid-operation: all full flags, FSM, counters, PEND and EN clear immediately.
//    No up_wr/up_rd is issued for transactions dropped by reset.
// TESTING
//  1. AW at cycle 0, W at cycle 3 (0x11223344, STRB=4'hF, addr 0x10)
//     -> one up_wr pulse in cycle 4 with up_addr=0x10, up_be=4'hF; BVALID from cycle 5.
//  2. W before AW, STRB=4'b0101 -> up_be=4'b0101, data forwarded unchanged.
//     Same write with STRB=0 -> no up_wr, BRESP=OKAY.
//  3. Read at addr 0x24, up_data_rd=0xCAFEF00D, RREADY held low 5 cycles
//     -> RVALID stays high and RDATA stays 0xCAFEF00D until RREADY.
//     Repeat with C_RD_LATENCY=3 and check RVALID timing shifts by 2 cycles.
//  4. Write-pair and AR complete in the same cycle, twice
//     -> order is write, read, then read, write (round-robin).
//  5. EN=0x5, pulse irq_src[0] and irq_src[1]
//     -> PEND=0x3, INTR_OUT=1 about 4 cycles later.
//     W1C 0x1 -> INTR_OUT=0; W1C coincident with a new irq_src[0] edge -> PEND[0] stays 1.
//  6. Assert reset during RWAIT and with AW full
//     -> RVALID=0, AWREADY=1 after release, no up_rd/up_wr issued afterwards.

Source files
------------

// File: rtl/ha1588_axi_lite_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// Module  : ha1588_axi_lite_bridge
// Brief   : AXI4-Lite slave to ha1588 up_* local bus, with maskable IRQ block
// Rev     : 1.0  initial release
// ==========================================================================
module ha1588_axi_lite_bridge #(
  parameter int C_S_AXI_REG_ADDR_WIDTH = 32,
  parameter int C_S_AXI_REG_DATA_WIDTH = 32,
  parameter int C_UP_ADDR_WIDTH        = 8,
  parameter int C_RD_LATENCY           = 1,
  parameter int C_INTR_WIDTH           = 4,
  parameter logic [C_UP_ADDR_WIDTH-1:0] C_INTR_BASE = 8'hF0
) (
  input  logic                                S_AXI_REG_ACLK,
  input  logic                                S_AXI_REG_ARESETN,
  input  logic [C_S_AXI_REG_ADDR_WIDTH-1:0]   S_AXI_REG_AWADDR,
  input  logic [2:0]                          S_AXI_REG_AWPROT,
  input  logic                                S_AXI_REG_AWVALID,
  output logic                                S_AXI_REG_AWREADY,
  input  logic [C_S_AXI_REG_DATA_WIDTH-1:0]   S_AXI_REG_WDATA,
  input  logic [C_S_AXI_REG_DATA_WIDTH/8-1:0] S_AXI_REG_WSTRB,
  input  logic                                S_AXI_REG_WVALID,
  output logic                                S_AXI_REG_WREADY,
  output logic [1:0]                          S_AXI_REG_BRESP,
  output logic                                S_AXI_REG_BVALID,
  input  logic                                S_AXI_REG_BREADY,
  input  logic [C_S_AXI_REG_ADDR_WIDTH-1:0]   S_AXI_REG_ARADDR,
  input  logic [2:0]                          S_AXI_REG_ARPROT,
  input  logic                                S_AXI_REG_ARVALID,
  output logic                                S_AXI_REG_ARREADY,
  output logic [C_S_AXI_REG_DATA_WIDTH-1:0]   S_AXI_REG_RDATA,
  output logic [1:0]                          S_AXI_REG_RRESP,
  output logic                                S_AXI_REG_RVALID,
  input  logic                                S_AXI_REG_RREADY,
  output logic                                INTR_OUT,
  input  logic [C_INTR_WIDTH-1:0]             irq_src,
  output logic                                up_wr,
  output logic                                up_rd,
  output logic [C_UP_ADDR_WIDTH-1:0]          up_addr,
  output logic [C_S_AXI_REG_DATA_WIDTH/8-1:0] up_be,
  output logic [C_S_AXI_REG_DATA_WIDTH-1:0]   up_data_wr,
  input  logic [C_S_AXI_REG_DATA_WIDTH-1:0]   up_data_rd
);

  localparam int DW = C_S_AXI_REG_DATA_WIDTH;
  localparam int UW = C_UP_ADDR_WIDTH;
  localparam logic [UW-1:0] c_EN_ADDR  = C_INTR_BASE + UW'(4);
  localparam logic [2:0]    c_LAT_LAST = 3'(C_RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WR    = 3'd1,
    S_BRSP  = 3'd2,
    S_RD    = 3'd3,
    S_RWAIT = 3'd4,
    S_RRSP  = 3'd5
  } state_t;

  state_t              r_state, w_state_nxt;
  logic                r_rst_done;
  logic                r_aw_full, r_w_full, r_ar_full;
  logic [UW-1:0]       r_aw_addr, r_ar_addr;
  logic [DW-1:0]       r_w_data;
  logic [DW/8-1:0]     r_w_strb;
  logic                r_prio_wr;
  logic [2:0]          r_lat_cnt;
  logic [1:0]          r_rd_sel;
  logic [DW-1:0]       r_rdata;
  logic [C_INTR_WIDTH-1:0] r_irq_s1, r_irq_s2, r_irq_s3, r_pend, r_en;
  logic                r_intr;

  logic                w_wr_rdy, w_rd_rdy, w_lat_done;
  logic                w_aw_pend, w_aw_en, w_ar_pend, w_ar_en;
  logic [DW-1:0]       w_bmask, w_pend_ext, w_en_ext;
  logic [C_INTR_WIDTH-1:0] w_irq_set, w_pend_clr, w_imask;
  logic                w_unused;

  // Only the local-bus slice of the AXI address and none of AxPROT are decoded.
  assign w_unused = ^{S_AXI_REG_AWPROT, S_AXI_REG_ARPROT,
                      S_AXI_REG_AWADDR[C_S_AXI_REG_ADDR_WIDTH-1:UW],
                      S_AXI_REG_ARADDR[C_S_AXI_REG_ADDR_WIDTH-1:UW]};

  assign S_AXI_REG_AWREADY = r_rst_done & ~r_aw_full;
  assign S_AXI_REG_WREADY  = r_rst_done & ~r_w_full;
  assign S_AXI_REG_ARREADY = r_rst_done & ~r_ar_full;
  assign S_AXI_REG_BVALID  = (r_state == S_BRSP);
  assign S_AXI_REG_RVALID  = (r_state == S_RRSP);
  assign S_AXI_REG_BRESP   = 2'b00;
  assign S_AXI_REG_RRESP   = 2'b00;
  assign S_AXI_REG_RDATA   = r_rdata;
  assign INTR_OUT          = r_intr;

  assign w_wr_rdy   = r_aw_full & r_w_full;
  assign w_rd_rdy   = r_ar_full;
  assign w_lat_done = (r_lat_cnt == c_LAT_LAST);
  assign w_aw_pend  = (r_aw_addr[UW-1:2] == C_INTR_BASE[UW-1:2]);
  assign w_aw_en    = (r_aw_addr[UW-1:2] == c_EN_ADDR[UW-1:2]);
  assign w_ar_pend  = (r_ar_addr[UW-1:2] == C_INTR_BASE[UW-1:2]);
  assign w_ar_en    = (r_ar_addr[UW-1:2] == c_EN_ADDR[UW-1:2]);

  assign up_wr      = (r_state == S_WR) && (|r_w_strb) && !(w_aw_pend || w_aw_en);
  assign up_rd      = (r_state == S_RD) && !(w_ar_pend || w_ar_en);
  assign up_addr    = (r_state == S_WR) ? r_aw_addr :
                      (r_state == S_RD) ? r_ar_addr : '0;
  assign up_be      = (r_state == S_WR) ? r_w_strb : '0;
  assign up_data_wr = (r_state == S_WR) ? r_w_data : '0;

  always_comb begin
    w_bmask    = '0;
    w_pend_ext = '0;
    w_en_ext   = '0;
    for (int b = 0; b < DW/8; b++) w_bmask[8*b +: 8] = {8{r_w_strb[b]}};
    w_pend_ext[C_INTR_WIDTH-1:0] = r_pend;
    w_en_ext[C_INTR_WIDTH-1:0]   = r_en;
  end

  assign w_imask    = w_bmask[C_INTR_WIDTH-1:0];
  assign w_irq_set  = r_irq_s2 & ~r_irq_s3;
  assign w_pend_clr = (r_state == S_WR && w_aw_pend) ? (r_w_data[C_INTR_WIDTH-1:0] & w_imask) : '0;

  // Holding registers: a handshake fills, the FSM drains when it issues the access.
  always_ff @(posedge S_AXI_REG_ACLK or negedge S_AXI_REG_ARESETN) begin
    if (!S_AXI_REG_ARESETN) begin
      r_rst_done <= 1'b0;
      r_aw_full  <= 1'b0;
      r_w_full   <= 1'b0;
      r_ar_full  <= 1'b0;
      r_aw_addr  <= '0;
      r_ar_addr  <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
    end else begin
      r_rst_done <= 1'b1;
      if (S_AXI_REG_AWVALID && S_AXI_REG_AWREADY) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= S_AXI_REG_AWADDR[UW-1:0];
      end else if (r_state == S_WR) begin
        r_aw_full <= 1'b0;
      end
      if (S_AXI_REG_WVALID && S_AXI_REG_WREADY) begin
        r_w_full <= 1'b1;
        r_w_data <= S_AXI_REG_WDATA;
        r_w_strb <= S_AXI_REG_WSTRB;
      end else if (r_state == S_WR) begin
        r_w_full <= 1'b0;
      end
      if (S_AXI_REG_ARVALID && S_AXI_REG_ARREADY) begin
        r_ar_full <= 1'b1;
        r_ar_addr <= S_AXI_REG_ARADDR[UW-1:0];
      end else if (r_state == S_RD) begin
        r_ar_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_REG_ACLK or negedge S_AXI_REG_ARESETN) begin
    if (!S_AXI_REG_ARESETN) r_state <= S_IDLE;
    else                    r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_wr_rdy && (!w_rd_rdy || r_prio_wr)) w_state_nxt = S_WR;
        else if (w_rd_rdy)                        w_state_nxt = S_RD;
      end
      S_WR:    w_state_nxt = S_BRSP;
      S_BRSP:  if (S_AXI_REG_BREADY) w_state_nxt = S_IDLE;
      S_RD:    w_state_nxt = S_RWAIT;
      S_RWAIT: if (w_lat_done) w_state_nxt = S_RRSP;
      S_RRSP:  if (S_AXI_REG_RREADY) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Priority only flips on contested grants, so an uncontested access never steals a turn.
  always_ff @(posedge S_AXI_REG_ACLK or negedge S_AXI_REG_ARESETN) begin
    if (!S_AXI_REG_ARESETN) begin
      r_prio_wr <= 1'b1;
      r_lat_cnt <= '0;
      r_rd_sel  <= '0;
      r_rdata   <= '0;
    end else begin
      if (r_state == S_IDLE && w_wr_rdy && w_rd_rdy) r_prio_wr <= ~r_prio_wr;
      if (r_state == S_RD) begin
        r_lat_cnt <= '0;
        r_rd_sel  <= {w_ar_en, w_ar_pend};
      end else if (r_state == S_RWAIT) begin
        r_lat_cnt <= r_lat_cnt + 3'd1;
        if (w_lat_done) begin
          if (r_rd_sel[0])      r_rdata <= w_pend_ext;
          else if (r_rd_sel[1]) r_rdata <= w_en_ext;
          else                  r_rdata <= up_data_rd;
        end
      end
    end
  end

  always_ff @(posedge S_AXI_REG_ACLK or negedge S_AXI_REG_ARESETN) begin
    if (!S_AXI_REG_ARESETN) begin
      r_irq_s1 <= '0;
      r_irq_s2 <= '0;
      r_irq_s3 <= '0;
      r_pend   <= '0;
      r_en     <= '0;
      r_intr   <= 1'b0;
    end else begin
      r_irq_s1 <= irq_src;
      r_irq_s2 <= r_irq_s1;
      r_irq_s3 <= r_irq_s2;
      r_pend   <= (r_pend & ~w_pend_clr) | w_irq_set;
      if (r_state == S_WR && w_aw_en)
        r_en <= (r_en & ~w_imask) | (r_w_data[C_INTR_WIDTH-1:0] & w_imask);
      r_intr   <= |(r_pend & r_en);
    end
  end

endmodule
`default_nettype wire
